gpr_wb_arbiter: RTL and testbench



---
 rtl/gpr_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/gpr_wb_arbiter.sv | 93 +++++++++
 tb/tb_gpr_wb_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// Shared GPR-file constants and helpers for the writeback path.
package gpr_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned AW      = 5;
    localparam int unsigned NUM_GPR = 32;

    localparam logic [AW-1:0] X0_ADDR = '0;

    // LSB position of slice idx in a flat bus of width-bit fields
    function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr, wrapping, found via a
// double-width masked priority search.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] masked;
    logic           found;

    // The upper copy of req covers the wrap-around below ptr.
    always_comb begin
        req_dbl   = {req, req};
        masked    = req_dbl & ({(2*N){1'b1}} << ptr);
        found     = 1'b0;
        grant_idx = '0;
        grant     = '0;
        for (int unsigned k = 0; k < 2*N; k++) begin
            if (!found && masked[k]) begin
                found     = 1'b1;
                grant_idx = PW'(k % N);
            end
        end
        if (en && found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Writeback arbiter for the GPR file's single write port: round-robin grant,
// registered write stage, in-flight forwarding and a contention counter.
module gpr_wb_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned XLEN    = gpr_pkg::XLEN,
    parameter int unsigned AW      = gpr_pkg::AW,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*AW-1:0]   req_rd,
    input  logic [NUM_REQ*XLEN-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic                    wb_stall,
    input  logic [AW-1:0]           rs1,
    input  logic [AW-1:0]           rs2,
    output logic                    gpr_wr_en,
    output logic [AW-1:0]           gpr_rd,
    output logic [XLEN-1:0]         gpr_data_wr,
    output logic                    fwd1_hit,
    output logic                    fwd2_hit,
    output logic [XLEN-1:0]         fwd_data,
    output logic [CNT_W-1:0]        contention
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]      ptr;
    logic [NUM_REQ-1:0] grant;
    logic [PW-1:0]      grant_idx;
    logic               handshake;
    logic               arb_en;
    logic [AW-1:0]      sel_rd;
    logic [XLEN-1:0]    sel_data;
    logic               multi_valid;

    assign arb_en = rst & ~wb_stall;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign handshake = |grant;

    always_comb begin
        sel_rd   = req_rd[gpr_pkg::slice_lsb(32'(grant_idx), AW) +: AW];
        sel_data = req_data[gpr_pkg::slice_lsb(32'(grant_idx), XLEN) +: XLEN];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (handshake) begin
            ptr <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // x0 requests complete the handshake but never assert the write enable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            gpr_wr_en   <= 1'b0;
            gpr_rd      <= '0;
            gpr_data_wr <= '0;
        end else begin
            gpr_wr_en <= handshake && (sel_rd != AW'(gpr_pkg::X0_ADDR));
            if (handshake) begin
                gpr_rd      <= sel_rd;
                gpr_data_wr <= sel_data;
            end
        end
    end

    assign fwd1_hit = gpr_wr_en && (gpr_rd == rs1) && (rs1 != AW'(gpr_pkg::X0_ADDR));
    assign fwd2_hit = gpr_wr_en && (gpr_rd == rs2) && (rs2 != AW'(gpr_pkg::X0_ADDR));
    assign fwd_data = gpr_data_wr;

    assign multi_valid = $countones(req_valid) > 1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            contention <= '0;
        end else if (multi_valid && (contention != '1)) begin
            contention <= contention + 1'b1;
        end
    end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter with an expected-write scoreboard and a
// behavioural GPR file fed from the write port.
module tb_gpr_wb_arbiter;

    localparam int NR = 4;
    localparam int XL = 32;
    localparam int A  = 5;
    localparam int CW = 16;

    typedef struct packed {
        logic          en;
        logic [A-1:0]  rd;
        logic [XL-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*A-1:0]   req_rd = '0;
    logic [NR*XL-1:0]  req_data = '0;
    logic [NR-1:0]     req_ready;
    logic              wb_stall = 1'b0;
    logic [A-1:0]      rs1 = '0;
    logic [A-1:0]      rs2 = '0;
    logic              gpr_wr_en;
    logic [A-1:0]      gpr_rd;
    logic [XL-1:0]     gpr_data_wr;
    logic              fwd1_hit;
    logic              fwd2_hit;
    logic [XL-1:0]     fwd_data;
    logic [CW-1:0]     contention;

    logic [XL-1:0] gpr_model [32] = '{default: '0};
    wr_t           sb [$];
    int            total = 0;
    int            bad   = 0;

    gpr_wb_arbiter #(.NUM_REQ(NR), .XLEN(XL), .AW(A), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_rd      (req_rd),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .wb_stall    (wb_stall),
        .rs1         (rs1),
        .rs2         (rs2),
        .gpr_wr_en   (gpr_wr_en),
        .gpr_rd      (gpr_rd),
        .gpr_data_wr (gpr_data_wr),
        .fwd1_hit    (fwd1_hit),
        .fwd2_hit    (fwd2_hit),
        .fwd_data    (fwd_data),
        .contention  (contention)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (gpr_wr_en) gpr_model[gpr_rd] <= gpr_data_wr;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [A-1:0] rd, input logic [XL-1:0] d);
        req_rd[i*A +: A]    = rd;
        req_data[i*XL +: XL] = d;
    endtask

    // One clock: drive at negedge, check ready, push the expected write,
    // then pop and check the write port just after the next posedge.
    task automatic cycle(input logic [NR-1:0] v, input logic stall,
                         input logic [NR-1:0] exp_ready, input logic drop_rst,
                         input string tag);
        wr_t e;
        int  g;
        @(negedge clk);
        req_valid = v;
        wb_stall  = stall;
        #1;
        check({tag, "/ready"}, 32'(req_ready), 32'(exp_ready));
        e = '0;
        g = 0;
        if (exp_ready != '0 && !drop_rst) begin
            for (int i = 0; i < NR; i++) if (exp_ready[i]) g = i;
            e.rd   = req_rd[g*A +: A];
            e.data = req_data[g*XL +: XL];
            e.en   = (e.rd != '0);
        end
        if (drop_rst) rst = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, "/wr_en"}, 32'(gpr_wr_en), 32'(e.en));
        if (e.en) begin
            check({tag, "/rd"}, 32'(gpr_rd), 32'(e.rd));
            check({tag, "/data"}, gpr_data_wr, e.data);
        end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) set_req(i, A'(10 + i), 32'h1000_0000 + 32'(i));

        // reset held with every requester valid
        for (int k = 0; k < 3; k++) begin
            cycle(4'b1111, 1'b0, 4'b0000, 1'b0, "reset");
            check("reset/contention", 32'(contention), 32'd0);
        end

        // single write from requester 1
        set_req(1, 5'd5, 32'hDEADBEEF);
        rst = 1'b1;
        cycle(4'b0010, 1'b0, 4'b0010, 1'b0, "single");
        cycle(4'b0000, 1'b0, 4'b0000, 1'b0, "idle");
        check("single/hold_rd", 32'(gpr_rd), 32'd5);
        check("single/gpr_x5", gpr_model[5], 32'hDEADBEEF);
        check("single/contention", 32'(contention), 32'd0);

        // round robin from ptr=0 with all four valid
        rst = 1'b0;
        cycle(4'b0000, 1'b0, 4'b0000, 1'b0, "rst2");
        rst = 1'b1;
        set_req(1, 5'd11, 32'h1000_0001);
        cycle(4'b1111, 1'b0, 4'b0001, 1'b0, "rr0");
        check("rr0/contention", 32'(contention), 32'd1);
        cycle(4'b1111, 1'b0, 4'b0010, 1'b0, "rr1");
        check("rr1/contention", 32'(contention), 32'd2);
        cycle(4'b1111, 1'b0, 4'b0100, 1'b0, "rr2");
        check("rr2/contention", 32'(contention), 32'd3);
        cycle(4'b1111, 1'b0, 4'b1000, 1'b0, "rr3");
        check("rr3/contention", 32'(contention), 32'd4);
        cycle(4'b1111, 1'b0, 4'b0001, 1'b0, "rr4");
        check("rr4/contention", 32'(contention), 32'd5);

        // x0 target: accepted, no write, pointer moves past requester 2
        set_req(2, 5'd0, 32'h0000_1234);
        cycle(4'b0100, 1'b0, 4'b0100, 1'b0, "x0");
        cycle(4'b1111, 1'b0, 4'b1000, 1'b0, "x0_ptr");
        check("x0/contention", 32'(contention), 32'd6);
        check("x0/gpr_x0", gpr_model[0], 32'd0);

        // stall then forward
        set_req(0, 5'd7, 32'hA5A5A5A5);
        rs1 = 5'd7;
        rs2 = 5'd0;
        cycle(4'b0001, 1'b1, 4'b0000, 1'b0, "stall");
        cycle(4'b0001, 1'b0, 4'b0001, 1'b0, "unstall");
        check("fwd/hit1", 32'(fwd1_hit), 32'd1);
        check("fwd/hit2_x0", 32'(fwd2_hit), 32'd0);
        check("fwd/data", fwd_data, 32'hA5A5A5A5);
        rs1 = 5'd0;
        rs2 = 5'd7;
        #1;
        check("fwd/hit1_x0", 32'(fwd1_hit), 32'd0);
        check("fwd/hit2", 32'(fwd2_hit), 32'd1);

        // reset lands right after a handshake
        set_req(1, 5'd9, 32'h0000_0077);
        cycle(4'b0010, 1'b0, 4'b0010, 1'b1, "midrst");
        check("midrst/contention", 32'(contention), 32'd0);
        rst = 1'b1;
        cycle(4'b0000, 1'b0, 4'b0000, 1'b0, "post");
        check("midrst/gpr_x9", gpr_model[9], 32'd0);
        check("midrst/gpr_x7", gpr_model[7], 32'hA5A5A5A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
